// File: rtl/sram_pkg.sv
// Shared types and defaults for the 32-bit data port to 16-bit SRAM bridge.
// Imported by the controller and its wait counter.
package sram_pkg;

  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 16;
  localparam int DEF_ADDR_BASE   = 1024;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait counter; tc_o marks the last cycle of a half access.
// Clear has priority over enable.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half
// first), holding ready low so the pipeline freezes until DONE.
module sram_controller
  import sram_pkg::*;
#(
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
  output logic                   SRAM_DQ_oe,
  input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
  output logic                   SRAM_WE_N
);

  state_e      state_q;
  state_e      state_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        latch;
  logic        cnt_clr;
  logic        cnt_en;
  logic        tc;
  logic [31:0] offset;
  logic        unused_offset;

  assign req = MEM_R_EN | MEM_W_EN;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear_i(cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          state_d = ST_LO;
          latch   = 1'b1;
        end
      end
      ST_LO: begin
        if (tc) begin
          state_d = ST_HI;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HI: begin
        if (tc) begin
          state_d = ST_DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (latch) begin
        wr_q    <= MEM_W_EN;
        addr_q  <= address;
        wdata_q <= writeData;
      end
      if (tc && !wr_q && state_q == ST_LO) begin
        rdata_q[15:0] <= SRAM_DQ_in;
      end
      if (tc && !wr_q && state_q == ST_HI) begin
        rdata_q[31:16] <= SRAM_DQ_in;
      end
    end
  end

  // Byte offset into SRAM; the two low bits select a byte and are dropped.
  assign offset        = addr_q - 32'(ADDR_BASE);
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  always_comb begin
    ready       = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    unique case (state_q)
      ST_IDLE: ready = ~req;
      ST_LO: begin
        SRAM_ADDR  = {offset[18:2], 1'b0};
        SRAM_WE_N  = ~wr_q;
        SRAM_DQ_oe = wr_q;
        if (wr_q) begin
          SRAM_DQ_out = wdata_q[15:0];
        end
      end
      ST_HI: begin
        SRAM_ADDR  = {offset[18:2], 1'b1};
        SRAM_WE_N  = ~wr_q;
        SRAM_DQ_oe = wr_q;
        if (wr_q) begin
          SRAM_DQ_out = wdata_q[31:16];
        end
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign readData = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Vector table of accesses against a behavioural SRAM, plus reset-abort
// and idle sequences.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_in;
  logic        SRAM_WE_N;

  logic [15:0] mem [0:1023];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] sbq[$];

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          drop;
    logic [17:0] exp_lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe (SRAM_DQ_oe),
    .SRAM_DQ_in (SRAM_DQ_in),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  assign SRAM_DQ_in = mem[SRAM_ADDR[9:0]];

  always @(posedge clk) begin
    if (!SRAM_WE_N && SRAM_DQ_oe) begin
      mem[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " we_n"}, 32'(SRAM_WE_N), 32'd1);
    chk({tag, " oe"}, 32'(SRAM_DQ_oe), 32'd0);
    chk({tag, " addr"}, 32'(SRAM_ADDR), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_rd;
    logic [17:0] ea;
    logic [15:0] ed;
    MEM_W_EN  = v.we;
    MEM_R_EN  = v.re;
    address   = v.addr;
    writeData = v.wdata;
    sbq.push_back(v.exp_rd);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (v.drop && c == 2) begin
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;
      end
      if (c == 0) begin
        chk("c0 ready", 32'(ready), 32'd0);
        chk_idle_bus("c0");
      end else if (c < 5) begin
        ea = v.exp_lo + ((c > 2) ? 18'd1 : 18'd0);
        ed = (c > 2) ? v.wdata[31:16] : v.wdata[15:0];
        chk("busy ready", 32'(ready), 32'd0);
        chk("sram addr", 32'(SRAM_ADDR), 32'(ea));
        chk("we_n", 32'(SRAM_WE_N), 32'(!v.we));
        chk("oe", 32'(SRAM_DQ_oe), 32'(v.we));
        if (v.we) begin
          chk("dq_out", 32'(SRAM_DQ_out), 32'(ed));
        end
      end else begin
        chk("c5 ready", 32'(ready), 32'd1);
        chk_idle_bus("c5");
        if (sbq.size() == 0) begin
          chk("scoreboard empty", 32'd1, 32'd0);
        end else begin
          exp_rd = sbq.pop_front();
          chk("readData", readData, exp_rd);
        end
      end
      @(posedge clk);
      #1;
    end
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    @(negedge clk);
    chk("no restart ready", 32'(ready), 32'd1);
    chk_idle_bus("after");
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'd1024, 32'hDEADBEEF, 0, 18'd0, 32'h0};
    vecs[1] = '{0, 1, 32'd1024, 32'h0, 0, 18'd0, 32'hDEADBEEF};
    vecs[2] = '{1, 0, 32'd1032, 32'h12345678, 0, 18'd4, 32'hDEADBEEF};
    vecs[3] = '{0, 1, 32'd1032, 32'h0, 0, 18'd4, 32'h12345678};
    vecs[4] = '{0, 1, 32'd1034, 32'h0, 0, 18'd4, 32'h12345678};
    vecs[5] = '{1, 1, 32'd1040, 32'hCAFEF00D, 1, 18'd8, 32'h12345678};
    vecs[6] = '{0, 1, 32'd1040, 32'h0, 0, 18'd8, 32'hCAFEF00D};
    vecs[7] = '{0, 1, 32'd1028, 32'h0, 0, 18'd2, 32'h0};

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    rst       = 1'b0;
    MEM_R_EN  = 1'b0;
    MEM_W_EN  = 1'b0;
    address   = '0;
    writeData = '0;

    #12;
    chk("rst ready", 32'(ready), 32'd1);
    chk_idle_bus("rst");
    chk("rst dq_out", 32'(SRAM_DQ_out), 32'd0);
    chk("rst readData", readData, 32'd0);
    MEM_R_EN = 1'b1;
    #1;
    chk("rst ready req", 32'(ready), 32'd0);
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("sb drained", 32'(sbq.size()), 32'd0);

    // Write aborted by reset during the high half.
    MEM_W_EN  = 1'b1;
    address   = 32'd1048;
    writeData = 32'h11225678;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("abort we_n before", 32'(SRAM_WE_N), 32'd0);
    chk("abort addr before", 32'(SRAM_ADDR), 32'd13);
    rst = 1'b0;
    #1;
    chk_idle_bus("abort");
    chk("abort readData", readData, 32'd0);
    chk("abort ready req", 32'(ready), 32'd0);
    MEM_W_EN = 1'b0;
    #1;
    chk("abort ready", 32'(ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post-abort ready", 32'(ready), 32'd1);
      chk_idle_bus("post-abort");
    end
    chk("abort lo written", 32'(mem[12]), 32'h5678);
    chk("abort hi untouched", 32'(mem[13]), 32'h0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle ready", 32'(ready), 32'd1);
      chk_idle_bus("idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-002 Parameter WAIT_CYCLES, default 2, cycles spent on each 16-bit half access; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 MEM_R_EN  in  1  read request from EX/MEM register.
REQ-006 MEM_W_EN  in  1  write request from EX/MEM register.
REQ-007 address  in  32  byte address (ALU result).
REQ-008 writeData  in  32  store data.
REQ-009 readData  out  32  load data to MEM/WB register (DataMemResIn).
REQ-010 ready  out  1  access complete; pipeline Freeze = ~ready.
REQ-011 SRAM_ADDR  out  18  SRAM half-word address.
REQ-012 SRAM_DQ_out  out  16  SRAM write data; SRAM_DQ_oe  out  1  drive enable; SRAM_DQ_in  in  16  SRAM read data.
REQ-013 SRAM_WE_N  out  1  SRAM write strobe, active-low.

Function
REQ-014 FSM states IDLE, LO, HI, DONE; wait counter 0..WAIT_CYCLES-1 in LO and HI.
REQ-015 IDLE: if MEM_W_EN or MEM_R_EN, next state LO, counter cleared, op latched (write if MEM_W_EN, else read), address and writeData latched.
REQ-016 MEM_W_EN and MEM_R_EN both high: write only.
REQ-017 LO: counter increments; at WAIT_CYCLES-1 next state HI, counter cleared.
REQ-018 HI: same rule; at WAIT_CYCLES-1 next state DONE.
REQ-019 DONE: lasts exactly one cycle, next state IDLE.
REQ-020 ready = 1 in IDLE with no request, and in DONE; 0 otherwise (combinational in IDLE).
REQ-021 Latency: request first seen in IDLE at cycle 0 -> ready high at cycle 2*WAIT_CYCLES+1 (cycle 5 at default).
REQ-022 offset = latched address - ADDR_BASE (32-bit, wraps); SRAM_ADDR = {offset[18:2],0} in LO, {offset[18:2],1} in HI; offset[1:0] ignored.
REQ-023 Write: SRAM_WE_N = 0 and SRAM_DQ_oe = 1 throughout LO and HI; SRAM_DQ_out = writeData[15:0] in LO, [31:16] in HI.
REQ-024 Read: SRAM_WE_N = 1, SRAM_DQ_oe = 0; SRAM_DQ_in captured into readData[15:0] on last LO cycle, readData[31:16] on last HI cycle.
REQ-025 readData holds last completed read value; writes never change it.
REQ-026 Requests dropped or changed after leaving IDLE are ignored; access completes on latched values.
REQ-027 In IDLE and DONE: SRAM_WE_N = 1, SRAM_DQ_oe = 0, SRAM_ADDR = 0.
REQ-028 Request still asserted in DONE (pipeline frozen one more edge) is not restarted; new access only from IDLE.

Reset
REQ-029 rst low: immediately state IDLE, counter 0, readData 0, SRAM_WE_N 1, SRAM_DQ_oe 0, SRAM_ADDR 0, SRAM_DQ_out 0; ready = ~(MEM_R_EN|MEM_W_EN).
REQ-030 Reset mid-access aborts it; no partial write completed after rst deasserts unless re-requested.

Structure
REQ-031 Package sram_pkg holds state encoding, SRAM_ADDR_W = 18, SRAM_DATA_W = 16, default ADDR_BASE/WAIT_CYCLES.
REQ-032 One sub-module sram_wait_counter (clear, enable, terminal-count output) instantiated once.

Verification
REQ-033 Write 0xDEADBEEF to 1024 -> LO: SRAM_ADDR 0, DQ_out 0xBEEF; HI: SRAM_ADDR 1, DQ_out 0xDEAD; WE_N low 4 cycles; ready high cycle 5.
REQ-034 Read 1024 with model returning the above -> readData 0xDEADBEEF at cycle 5, ready low cycles 0-4.
REQ-035 Read 1032 -> SRAM_ADDR 4 then 5; address 1034 gives same addresses.
REQ-036 MEM_W_EN=MEM_R_EN=1 -> write performed, readData unchanged; request deasserted at cycle 2 -> access still completes cycle 5.
REQ-037 rst low at cycle 3 of write -> WE_N high, DQ_oe low same cycle; IDLE after release.
REQ-038 No requests 20 cycles -> ready constant 1, WE_N 1, no SRAM activity.
